cla_nibble_sequencer: RTL and testbench
=======================================

Name: cla_nibble_sequencer

Overview:
Multi-cycle add/subtract controller that time-shares one external 4-bit carry-lookahead adder slice to produce a full register-width result, one nibble per clock, LSB nibble first. It sits between the CPU execute stage and a single shared 4-bit CLA instance. It owns operand latching, the carry chain between nibbles, the nibble counter and the flag generation. It exposes a start/busy/done handshake to the execute stage.

Parameters:
NIBBLES, 3, number of 4-bit slices per operation; datapath width W = 4*NIBBLES (12 bits at default); legal range 2..8.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high; clears all state and outputs
start  input  1  one-cycle request; sampled only in IDLE
sub  input  1  0 = A+B, 1 = A-B; sampled with start
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
cla_a  output  4  nibble of A driven to the shared CLA
cla_b  output  4  nibble of B (inverted when sub) driven to the CLA
cla_cin  output  1  carry-in driven to the CLA
cla_s  input  4  CLA sum, combinational from cla_a/cla_b/cla_cin
cla_cout  input  1  CLA carry-out
busy  output  1  high while nibbles are being processed
done  output  1  one-cycle pulse; result and flags valid from this cycle onward
result  output  W  final sum/difference; held until the next completion
cout  output  1  final carry; for sub, 1 = no borrow
overflow  output  1  signed two's-complement overflow
zero  output  1  result == 0

Behaviour:
- Reset: state=IDLE; busy, done, cout, overflow, zero = 0; result = 0; the internal counter, carry, accumulator and operand registers = 0. Reset asserted mid-operation aborts immediately; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1:
  - a_reg <= a
  - b_reg <= sub ? ~b : b
  - carry <= sub
  - cnt <= 0
  - acc <= 0
- RUN:
  - busy=1.
  - Combinationally drive cla_a = a_reg[4*cnt+:4], cla_b = b_reg[4*cnt+:4], cla_cin = carry.
  - Each edge: acc[4*cnt+:4] <= cla_s, carry <= cla_cout, cnt <= cnt+1.
  - When cnt == NIBBLES-1 at the edge: go to DONE, and load result, cout and the flags from the completed value (acc with the last nibble merged, plus cla_cout).
- DONE: done=1 and busy=0 for exactly one cycle, then unconditional return to IDLE.
- Outside RUN: cla_a, cla_b and cla_cin drive 0.
- Latency: start sampled at edge E0; nibbles captured at edges E1..E_NIBBLES; done is high during the cycle after edge E_NIBBLES. Default: done in the 4th cycle after the start edge. Back-to-back throughput is one operation per NIBBLES+2 cycles.
- start is ignored in RUN and DONE, with no queuing. sub, a and b may change freely after the start edge.
- Flags, all registered and updated only on the RUN->DONE edge:
  - overflow = (a_reg[W-1] == b_reg[W-1]) && (result[W-1] != a_reg[W-1]), where b_reg is the already-inverted operand.
  - zero = (result == 0).
  - cout = final cla_cout.
- result and the flags hold their values through IDLE and the next RUN; they change only at the next completion or at reset.
- Wrap-around: the sum is modulo 2^W; carry beyond bit W-1 is reported only via cout.
- start asserted in the same cycle as rst: rst wins.

Test Plan:
- add 0x123 + 0x456, start at E0 -> busy during E1..E3, done one cycle after E3; result=0x579, cout=0, overflow=0, zero=0.
- add 0xFFF + 0x001 -> result=0x000, cout=1, zero=1, overflow=0; the carry must ripple through all three nibbles (check cla_cin=1 on nibbles 1 and 2).
- add 0x7FF + 0x001 -> result=0x800, overflow=1, cout=0. Then sub 0x800 - 0x001 -> result=0x7FF, overflow=1, cout=1.
- sub 0x005 - 0x007 -> result=0xFFE, cout=0 (borrow), overflow=0, zero=0; cla_b for nibble 0 = 0x8 and cla_cin = 1.
- start pulsed again during busy with different operands -> ignored; the first operation completes with its own result, and exactly one done pulse is seen.
- rst raised during RUN (after nibble 1) -> next cycle busy=0, done never pulses, result=0. A subsequent 0x00A + 0x005 completes to 0x00F with normal latency.

Source files
------------

// File: rtl/cla_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_sequencer
// Brief    : Multi-cycle add/subtract controller that time-shares one external
//            4-bit carry-lookahead slice. It processes one nibble per clock,
//            LSB first, and produces a W-bit result with carry, overflow and
//            zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module cla_nibble_sequencer #(
    parameter int NIBBLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic [3:0]           cla_a,
    output logic [3:0]           cla_b,
    output logic                 cla_cin,
    input  logic [3:0]           cla_s,
    input  logic                 cla_cout,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 overflow,
    output logic                 zero
);

    localparam int W                    = 4 * NIBBLES;
    localparam int c_CNT_W              = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [c_CNT_W-1:0]   cnt_q,    cnt_d;
    logic                 carry_q,  carry_d;
    logic [W-1:0]         acc_q,    acc_d;
    logic [W-1:0]         a_reg_q,  a_reg_d;
    logic [W-1:0]         b_reg_q,  b_reg_d;
    logic [W-1:0]         result_q, result_d;
    logic                 cout_q,   cout_d;
    logic                 ovf_q,    ovf_d;
    logic                 zero_q,   zero_d;

    logic [3:0]           w_nib_a;
    logic [3:0]           w_nib_b;
    logic [W-1:0]         w_merged;

    // Select the current operand nibbles and merge the CLA sum into the accumulator
    always_comb begin
        w_nib_a  = 4'h0;
        w_nib_b  = 4'h0;
        w_merged = acc_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == c_CNT_W'(i)) begin
                w_nib_a             = a_reg_q[4*i +: 4];
                w_nib_b             = b_reg_q[4*i +: 4];
                w_merged[4*i +: 4]  = cla_s;
            end
        end
    end

    // Next-state, datapath updates and outputs of the nibble sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        a_reg_d  = a_reg_q;
        b_reg_d  = b_reg_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        busy     = 1'b0;
        done     = 1'b0;
        cla_a    = 4'h0;
        cla_b    = 4'h0;
        cla_cin  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B here and seed the carry.
                    a_reg_d = a;
                    b_reg_d = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                cla_a   = w_nib_a;
                cla_b   = w_nib_b;
                cla_cin = carry_q;
                acc_d   = w_merged;
                carry_d = cla_cout;
                cnt_d   = cnt_q + c_CNT_W'(1);
                if (cnt_q == c_LAST_CNT) begin
                    state_d  = DONE;
                    result_d = w_merged;
                    cout_d   = cla_cout;
                    ovf_d    = (a_reg_q[W-1] == b_reg_q[W-1]) &&
                               (w_merged[W-1] != a_reg_q[W-1]);
                    zero_d   = (w_merged == '0);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            a_reg_q  <= '0;
            b_reg_q  <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            a_reg_q  <= a_reg_d;
            b_reg_q  <= b_reg_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_nibble_sequencer
// Brief    : Self-checking bench for cla_nibble_sequencer with a behavioural
//            4-bit CLA slice and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_nibble_sequencer;

    localparam int NIBBLES = 3;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   cla_a;
    logic [3:0]   cla_b;
    logic         cla_cin;
    logic [3:0]   cla_s;
    logic         cla_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;

    int tests_run;
    int tests_failed;

    logic [W-1:0] exp_prev;
    logic [7:0]   cin_seen;
    logic [3:0]   clab_seen [8];

    cla_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cla_a    (cla_a),
        .cla_b    (cla_b),
        .cla_cin  (cla_cin),
        .cla_s    (cla_s),
        .cla_cout (cla_cout),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    // Shared external 4-bit adder slice
    assign {cla_cout, cla_s} = {1'b0, cla_a} + {1'b0, cla_b} + {4'h0, cla_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {overflow, zero, cout, result} from plain integer arithmetic
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        int ux, uy, sx, sy, sres, full;
        logic [W-1:0] res;
        logic co, ov, z;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= (1 << (W-1))) ? ux - (1 << W) : ux;
        sy = (uy >= (1 << (W-1))) ? uy - (1 << W) : uy;
        if (s) begin
            full = ux - uy;
            co   = (ux >= uy);
            sres = sx - sy;
        end else begin
            full = ux + uy;
            co   = (full >= (1 << W));
            sres = sx + sy;
        end
        res = W'(full & ((1 << W) - 1));
        ov  = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
        z   = (res == '0);
        return {ov, z, co, res};
    endfunction

    // Launch one operation and observe it until done (bounded)
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                          output logic [W-1:0] r, output logic co, output logic ov,
                          output logic z, output int lat, output int nbusy,
                          output int hold_err, output logic post_done);
        r = '0; co = 1'b0; ov = 1'b0; z = 1'b0;
        lat = -1; nbusy = 0; hold_err = 0; post_done = 1'b0;
        cin_seen = '0;
        for (int k = 0; k < 8; k++) clab_seen[k] = 4'h0;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; sub = isub;
        @(posedge clk);
        #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (busy) begin
                if (nbusy < 8) begin
                    cin_seen[nbusy]  = cla_cin;
                    clab_seen[nbusy] = cla_b;
                end
                nbusy++;
                if (result !== exp_prev) hold_err++;
            end
            if (done) begin
                lat = c; r = result; co = cout; ov = overflow; z = zero;
                break;
            end
        end
        @(negedge clk);
        post_done = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake: busy=%b done=%b expected 0 0", busy, done);
        end
        tests_run++;
        if (result !== '0 || cout !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: result=%h cout=%b ovf=%b zero=%b expected all 0",
                     result, cout, overflow, zero);
        end
        tests_run++;
        if (cla_a !== 4'h0 || cla_b !== 4'h0 || cla_cin !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_cla: cla_a=%h cla_b=%h cin=%b expected 0", cla_a, cla_b, cla_cin);
        end
        rst = 1'b0;
        exp_prev = '0;
    endtask

    task automatic test_add_basic();
        logic [W-1:0] r; logic co, ov, z, pd; int lat, nb, he;
        run_op(12'h123, 12'h456, 1'b0, r, co, ov, z, lat, nb, he, pd);
        tests_run++;
        if (r !== 12'h579 || co !== 1'b0 || ov !== 1'b0 || z !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_basic: got r=%h c=%b v=%b z=%b expected 579 0 0 0", r, co, ov, z);
        end
        tests_run++;
        if (lat !== NIBBLES + 1 || nb !== NIBBLES) begin
            tests_failed++;
            $display("FAIL add_latency: lat=%0d busy=%0d expected %0d %0d", lat, nb, NIBBLES + 1, NIBBLES);
        end
        tests_run++;
        if (pd !== 1'b0 || he !== 0) begin
            tests_failed++;
            $display("FAIL add_pulse_hold: post_done=%b hold_err=%0d expected 0 0", pd, he);
        end
        exp_prev = 12'h579;
    endtask

    task automatic test_ripple();
        logic [W-1:0] r; logic co, ov, z, pd; int lat, nb, he;
        run_op(12'hFFF, 12'h001, 1'b0, r, co, ov, z, lat, nb, he, pd);
        tests_run++;
        if (r !== 12'h000 || co !== 1'b1 || ov !== 1'b0 || z !== 1'b1) begin
            tests_failed++;
            $display("FAIL ripple_result: got r=%h c=%b v=%b z=%b expected 000 1 0 1", r, co, ov, z);
        end
        tests_run++;
        if (cin_seen[0] !== 1'b0 || cin_seen[1] !== 1'b1 || cin_seen[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ripple_cin: got %b%b%b expected cin n2n1n0=110",
                     cin_seen[2], cin_seen[1], cin_seen[0]);
        end
        exp_prev = 12'h000;
    endtask

    task automatic test_overflow();
        logic [W-1:0] r; logic co, ov, z, pd; int lat, nb, he;
        run_op(12'h7FF, 12'h001, 1'b0, r, co, ov, z, lat, nb, he, pd);
        tests_run++;
        if (r !== 12'h800 || co !== 1'b0 || ov !== 1'b1 || z !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_add: got r=%h c=%b v=%b z=%b expected 800 0 1 0", r, co, ov, z);
        end
        exp_prev = 12'h800;
        run_op(12'h800, 12'h001, 1'b1, r, co, ov, z, lat, nb, he, pd);
        tests_run++;
        if (r !== 12'h7FF || co !== 1'b1 || ov !== 1'b1 || z !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_sub: got r=%h c=%b v=%b z=%b expected 7ff 1 1 0", r, co, ov, z);
        end
        tests_run++;
        if (he !== 0) begin
            tests_failed++;
            $display("FAIL ovf_hold: hold_err=%0d expected 0", he);
        end
        exp_prev = 12'h7FF;
    endtask

    task automatic test_sub_borrow();
        logic [W-1:0] r; logic co, ov, z, pd; int lat, nb, he;
        run_op(12'h005, 12'h007, 1'b1, r, co, ov, z, lat, nb, he, pd);
        tests_run++;
        if (r !== 12'hFFE || co !== 1'b0 || ov !== 1'b0 || z !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_borrow: got r=%h c=%b v=%b z=%b expected ffe 0 0 0", r, co, ov, z);
        end
        tests_run++;
        if (clab_seen[0] !== 4'h8 || cin_seen[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_nibble0: cla_b=%h cin=%b expected 8 1", clab_seen[0], cin_seen[0]);
        end
        exp_prev = 12'hFFE;
    endtask

    task automatic test_ignore_start();
        int ndone;
        logic [W-1:0] r;
        ndone = 0; r = '0;
        @(negedge clk);
        start = 1'b1; a = 12'h123; b = 12'h456; sub = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                r = result;
            end
            if (c == 2 || c == 4) begin
                start = 1'b1; a = 12'h111; b = 12'h222; sub = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        tests_run++;
        if (ndone !== 1) begin
            tests_failed++;
            $display("FAIL ignore_start_count: done pulses=%0d expected 1", ndone);
        end
        tests_run++;
        if (r !== 12'h579) begin
            tests_failed++;
            $display("FAIL ignore_start_result: got %h expected 579", r);
        end
        exp_prev = 12'h579;
    endtask

    task automatic test_reset_midrun();
        int ndone;
        logic [W-1:0] r; logic co, ov, z, pd; int lat, nb, he;
        ndone = 0;
        @(negedge clk);
        start = 1'b1; a = 12'h0F0; b = 12'h010; sub = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            tests_failed++;
            $display("FAIL midrun_reset: busy=%b done=%b result=%h expected 0 0 000", busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_prev = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        tests_run++;
        if (ndone !== 0) begin
            tests_failed++;
            $display("FAIL midrun_no_done: done pulses=%0d expected 0", ndone);
        end
        run_op(12'h00A, 12'h005, 1'b0, r, co, ov, z, lat, nb, he, pd);
        tests_run++;
        if (r !== 12'h00F || co !== 1'b0 || z !== 1'b0 || lat !== NIBBLES + 1) begin
            tests_failed++;
            $display("FAIL after_reset_op: got r=%h c=%b z=%b lat=%0d expected 00f 0 0 %0d",
                     r, co, z, lat, NIBBLES + 1);
        end
        exp_prev = 12'h00F;
    endtask

    task automatic test_back_to_back();
        int ndone, first, second;
        logic [W-1:0] r;
        ndone = 0; first = -1; second = -1; r = '0;
        @(negedge clk);
        start = 1'b1; a = 12'h321; b = 12'h123; sub = 1'b0;
        for (int c = 1; c <= 3 * (NIBBLES + 2); c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                r = result;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        start = 1'b0;
        tests_run++;
        if (ndone !== 3 || first !== NIBBLES + 1 || second - first !== NIBBLES + 2) begin
            tests_failed++;
            $display("FAIL back_to_back: dones=%0d first=%0d spacing=%0d expected 3 %0d %0d",
                     ndone, first, second - first, NIBBLES + 1, NIBBLES + 2);
        end
        tests_run++;
        if (r !== 12'h444) begin
            tests_failed++;
            $display("FAIL back_to_back_result: got %h expected 444", r);
        end
        repeat (NIBBLES + 2) @(negedge clk);
        exp_prev = 12'h444;
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, r; logic rs, co, ov, z, pd; int lat, nb, he;
        logic [W+2:0] e;
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            if (n == 0) begin ra = 12'h800; rb = 12'h800; rs = 1'b0; end
            if (n == 1) begin ra = 12'hABC; rb = 12'hABC; rs = 1'b1; end
            e = model(ra, rb, rs);
            run_op(ra, rb, rs, r, co, ov, z, lat, nb, he, pd);
            tests_run++;
            if (r !== e[W-1:0] || co !== e[W] || z !== e[W+1] || ov !== e[W+2]) begin
                tests_failed++;
                $display("FAIL random_op %0d: %h %s %h got r=%h c=%b z=%b v=%b expected r=%h c=%b z=%b v=%b",
                         n, ra, rs ? "-" : "+", rb, r, co, z, ov, e[W-1:0], e[W], e[W+1], e[W+2]);
            end
            tests_run++;
            if (lat !== NIBBLES + 1 || pd !== 1'b0 || he !== 0) begin
                tests_failed++;
                $display("FAIL random_timing %0d: lat=%0d post_done=%b hold_err=%0d expected %0d 0 0",
                         n, lat, pd, he, NIBBLES + 1);
            end
            exp_prev = e[W-1:0];
        end
    endtask

    // Test sequence
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_prev     = '0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        test_reset();
        test_add_basic();
        test_ripple();
        test_overflow();
        test_sub_borrow();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
